// File: rtl/mem_ctrl_nch.sv
// mem_ctrl_nch: serialises NUM_CH 1/2/4-byte little-endian load/store requests onto a byte-wide memory bus
// Build option MEMCTL_RR_EN: round-robin arbitration starting after the last granted channel;
// without it, fixed priority with channel 0 highest and no pointer.
// Ports: clk, rst (sync, active-high), rdy (low freezes the block);
//   req_valid/req_wr/req_size/req_addr/req_wdata per-channel request, req_ready one-hot grant;
//   resp_valid one-hot completion pulse with resp_data (load data, 0 for stores); busy while in flight;
//   mem_din read byte (one cycle after mem_a), mem_dout/mem_a/mem_wr write/address bus.
module mem_ctrl_nch #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [2*NUM_CH-1:0]      req_size,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [31:0]              resp_data,
  output logic                     busy,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_nx;
  logic [CW-1:0] gnt_idx, ch_q;
  logic gnt_any, accept, issue, cap, last, wr_q;
  logic [1:0] sz_sel, bidx;
  logic [2:0] len_q, cnt;
  logic [ADDR_W-1:0] addr_q, mem_a_q;
  logic [31:0] wdata_q, rbuf, rbuf_nx;
  logic [NUM_CH-1:0] rv_q;
`ifdef MEMCTL_RR_EN
  logic [CW-1:0] ptr;
  // Lowest requester above ptr wins; otherwise wrap to the lowest at or below ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (req_valid[k] && k <= int'(ptr)) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(k);
      end
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (req_valid[k] && k > int'(ptr)) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(k);
      end
  end
  always_ff @(posedge clk)
    if (rst) ptr <= CW'(NUM_CH - 1);
    else if (accept) ptr <= gnt_idx;
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(k);
      end
  end
`endif
  assign busy = state == XFER;
  assign accept = !busy && rdy && !rst && gnt_any;
  assign req_ready = accept ? NUM_CH'(1) << gnt_idx : '0;
  assign sz_sel = req_size[gnt_idx*2 +: 2];
  assign issue = busy && cnt < len_q;
  // Loads see each byte one cycle after its address, so capture trails issue by one count.
  assign cap = busy && !wr_q && cnt != 3'd0;
  assign last = wr_q ? cnt == len_q - 3'd1 : cnt == len_q;
  assign bidx = 2'(cnt - 3'd1);
  assign resp_valid = rv_q & {NUM_CH{rdy}};
  // Under a stall the address is held so the byte read during the last stalled cycle is
  // the one whose capture was deferred; capture then resumes with no byte lost.
  assign mem_a = rdy ? (issue ? addr_q + ADDR_W'(cnt) : '0) : mem_a_q;
  assign mem_wr = rdy && issue && wr_q;
  assign mem_dout = mem_wr ? wdata_q[{cnt[1:0], 3'b000} +: 8] : '0;
  always_comb begin
    rbuf_nx = rbuf;
    if (cap) rbuf_nx[{bidx, 3'b000} +: 8] = mem_din;
  end
  always_comb state_nx = busy ? (last ? IDLE : XFER) : (accept ? XFER : IDLE);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rbuf <= '0;
      rv_q <= '0;
      resp_data <= '0;
      mem_a_q <= '0;
    end else begin
      mem_a_q <= mem_a;
      if (rdy) begin
        state <= state_nx;
        cnt <= accept ? 3'd0 : busy ? cnt + 3'd1 : cnt;
        rbuf <= accept ? '0 : rbuf_nx;
        rv_q <= busy && last ? NUM_CH'(1) << ch_q : '0;
        if (busy && last) resp_data <= wr_q ? '0 : rbuf_nx;
      end
    end
  always_ff @(posedge clk)
    if (accept) begin
      ch_q <= gnt_idx;
      wr_q <= req_wr[gnt_idx];
      addr_q <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
      wdata_q <= req_wdata[gnt_idx*32 +: 32];
      len_q <= sz_sel == 2'b00 ? 3'd1 : sz_sel == 2'b01 ? 3'd2 : 3'd4;
    end
endmodule
